ex_stage_ex_mem: RTL and testbench
==================================

Name: ex_stage_ex_mem

Overview:
- Execute stage plus EX/MEM pipeline register; consumes ID/EX register outputs and feeds the MEM stage.
- Performs ALU control decode, operand forwarding select, ALU, branch-target/zero computation and destination-register select.
- Contains an iterative 32-cycle multiplier; requests a stall while it runs.
- State updates on the falling edge of clk, matching the other pipeline registers.

Parameters:
- DATA_W, 32, datapath width.
- MUL_CYCLES, 32, multiplier iterations; must equal DATA_W.

Ports:
- clk  in  1  pipeline clock; state updates on negedge.
- reset  in  1  asynchronous, active-high reset.
- reg_write_out_id_ex, mem_to_reg_out_id_ex, mem_write_out_id_ex, mem_read_out_id_ex, branch_out_id_ex, alu_src_out_id_ex, reg_dst_id_ex  in  1 each  control from ID/EX.
- alu_op_out_id_ex  in  2  ALU op class.
- nextpc_out, reg_file_out_data1, reg_file_out_data2, sgn_ext_imm_out  in  32 each  ID/EX data.
- rd_out_id_ex, inst_read_reg_addr2_out_id_ex  in  5 each  rd, rt.
- fwd_a_sel, fwd_b_sel  in  2 each  00 regfile, 01 mem_fwd_data, 10 wb_fwd_data, 11 regfile.
- mem_fwd_data, wb_fwd_data  in  32 each  forwarded values.
- flush  in  1  squash the instruction entering EX/MEM.
- ex_busy  out  1  stall request to the hazard unit.
- reg_write_out_ex_mem, mem_to_reg_out_ex_mem, mem_write_out_ex_mem, mem_read_out_ex_mem, branch_out_ex_mem, zero_out_ex_mem  out  1 each  registered.
- branch_target_out_ex_mem, alu_result_out_ex_mem, write_data_out_ex_mem  out  32 each  registered.
- write_reg_out_ex_mem  out  5  registered destination register.

Behaviour:
- Operand A is the fwd_a_sel mux result.
- Operand B pre-source (B0) is the fwd_b_sel mux result.
- ALU B is sgn_ext_imm_out when alu_src_out_id_ex=1, else B0.
- write_data is B0.
- ALU control:
  - alu_op 00: ADD. 01: SUB. 11: SLT (signed).
  - alu_op 10 decodes funct = sgn_ext_imm_out[5:0]: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x18 MUL (low 32 bits of signed product).
  - Any other funct yields result 0.
- Arithmetic wraps mod 2^32, with no overflow flag.
- zero = (ALU result == 0). zero is computed on the SUB result for alu_op 01.
- branch_target = nextpc_out + (sgn_ext_imm_out << 2), wrapping.
- write_reg = reg_dst_id_ex ? rd_out_id_ex : inst_read_reg_addr2_out_id_ex.
- Non-MUL instructions have 1-cycle latency: combinational EX, captured at the next negedge.
- Multiplier FSM:
  - IDLE: ex_busy = (decoded op is MUL). On negedge with a MUL, capture operands, count = 0, go to MUL.
  - MUL: ex_busy = 1. One shift-add iteration per negedge. After iteration MUL_CYCLES-1, go to DONE.
  - DONE: ex_busy = 0. The ALU result mux selects the product. At the next negedge the product is captured in EX/MEM and the FSM returns to IDLE.
  - Total: 34 negedges from first presentation to capture. The ID/EX contents must stay stable while ex_busy=1; this is the hazard unit's responsibility.
- EX/MEM update at negedge, in priority order:
  1. flush=1: bubble.
  2. ex_busy=1: bubble.
  3. Otherwise: capture all computed values.
- Bubble: all control outputs 0, data outputs 0, write_reg 0.
- flush in MUL or DONE aborts the multiply: FSM returns to IDLE and the product is discarded.
- Reset (async, any time including mid-multiply): FSM IDLE, count 0, every registered output 0. ex_busy then reflects the inputs combinationally.
- A back-to-back MUL after DONE re-enters MUL normally.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: multiplier FSM present as above.
- Undefined:
  - No FSM; ex_busy tied 0.
  - funct 0x18 treated as an unknown funct (result 0).
  - Single-cycle behaviour for all ops.

Decomposition:
- Shared package pipe_pkg:
  - ALU control enum: ADD, SUB, AND, OR, SLT, MUL, NOP.
  - funct constants: 0x20, 0x22, 0x24, 0x25, 0x2A, 0x18.
  - alu_op encodings.
  - Forwarding-select encodings.
  - Multiplier FSM state enum.
- One natural sub-module: ex_seq_mul, the iterative multiplier with start, busy, done and product.

Test Plan:
1. Reset asserted between clock edges → all registered outputs 0 immediately, ex_busy=0 with NOP inputs.
2. alu_op 10, funct 0x22, data1=5, data2=7 → alu_result 0xFFFFFFFE, zero 0. alu_op 01, both 9 → zero 1.
3. fwd_a_sel=01, mem_fwd_data=0x10, alu_src=1, imm=0xFFFFFFFC, alu_op 00 → alu_result 0x0000000C.
4. branch, nextpc=0x100, imm=0xFFFFFFFF → branch_target 0x000000FC. reg_dst=0, rt=7 → write_reg 7.
5. MUL of 0xFFFFFFFD × 6 → ex_busy high for 33 negedges, bubbles emitted, then alu_result 0xFFFFFFEE with reg_write 1.
6. flush asserted at iteration 10 of a MUL → bubble, FSM IDLE, ex_busy 0. A reset mid-MUL gives the same result with all outputs 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ALU control, funct, alu_op, forwarding and multiplier state encodings
package pipe_pkg;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL, ALU_NOP} alu_ctl_t;
  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLT = 2'b11;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  function automatic alu_ctl_t alu_decode(input logic [1:0] op, input logic [5:0] funct, input bit mul_en);
    return op == ALUOP_ADD ? ALU_ADD :
           op == ALUOP_SUB ? ALU_SUB :
           op == ALUOP_SLT ? ALU_SLT :
           funct == FUNCT_ADD ? ALU_ADD :
           funct == FUNCT_SUB ? ALU_SUB :
           funct == FUNCT_AND ? ALU_AND :
           funct == FUNCT_OR  ? ALU_OR  :
           funct == FUNCT_SLT ? ALU_SLT :
           (funct == FUNCT_MUL && mul_en) ? ALU_MUL : ALU_NOP;
  endfunction
endpackage

// File: rtl/ex_seq_mul.sv
// ex_seq_mul: iterative shift-add multiplier, one iteration per falling clock edge
module ex_seq_mul
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic busy,
  output logic done,
  output logic [DATA_W-1:0] product
);
  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);
  mul_state_t state, state_nxt;
  logic [DATA_W-1:0] a_r, b_r;
  logic [CW-1:0] count;
  always_ff @(negedge clk or posedge reset)
    if (reset) begin
      state <= MUL_IDLE;
      a_r <= '0;
      b_r <= '0;
      product <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == MUL_IDLE && start) begin
        a_r <= a;
        b_r <= b;
        product <= '0;
        count <= '0;
      end else if (state == MUL_RUN) begin
        product <= a_r[0] ? product + b_r : product;
        a_r <= a_r >> 1;
        b_r <= b_r << 1;
        count <= count + 1'b1;
      end
    end
  // the low word of the unsigned product equals the low word of the signed product
  always_comb
    state_nxt = abort ? MUL_IDLE :
                state == MUL_IDLE ? (start ? MUL_RUN : MUL_IDLE) :
                state == MUL_RUN ? (count == LAST ? MUL_DONE : MUL_RUN) : MUL_IDLE;
  always_comb begin
    busy = state == MUL_RUN;
    done = state == MUL_DONE;
  end
endmodule

// File: rtl/ex_stage_ex_mem.sv
// ex_stage_ex_mem: execute stage and EX/MEM register, negedge-updated
// EX_MUL_EN adds the iterative multiplier (funct 0x18) with a stall request while it runs.
module ex_stage_ex_mem
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic reg_write_out_id_ex,
  input  logic mem_to_reg_out_id_ex,
  input  logic mem_write_out_id_ex,
  input  logic mem_read_out_id_ex,
  input  logic branch_out_id_ex,
  input  logic alu_src_out_id_ex,
  input  logic reg_dst_id_ex,
  input  logic [1:0] alu_op_out_id_ex,
  input  logic [DATA_W-1:0] nextpc_out,
  input  logic [DATA_W-1:0] reg_file_out_data1,
  input  logic [DATA_W-1:0] reg_file_out_data2,
  input  logic [DATA_W-1:0] sgn_ext_imm_out,
  input  logic [4:0] rd_out_id_ex,
  input  logic [4:0] inst_read_reg_addr2_out_id_ex,
  input  logic [1:0] fwd_a_sel,
  input  logic [1:0] fwd_b_sel,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic [DATA_W-1:0] wb_fwd_data,
  input  logic flush,
  output logic ex_busy,
  output logic reg_write_out_ex_mem,
  output logic mem_to_reg_out_ex_mem,
  output logic mem_write_out_ex_mem,
  output logic mem_read_out_ex_mem,
  output logic branch_out_ex_mem,
  output logic zero_out_ex_mem,
  output logic [DATA_W-1:0] branch_target_out_ex_mem,
  output logic [DATA_W-1:0] alu_result_out_ex_mem,
  output logic [DATA_W-1:0] write_data_out_ex_mem,
  output logic [4:0] write_reg_out_ex_mem
);
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  alu_ctl_t ctl;
  logic [DATA_W-1:0] op_a, op_b0, op_b, alu_res, mul_product;
  logic is_mul, mul_busy, mul_done;
  always_comb begin
    op_a = fwd_a_sel == FWD_MEM ? mem_fwd_data : fwd_a_sel == FWD_WB ? wb_fwd_data : reg_file_out_data1;
    op_b0 = fwd_b_sel == FWD_MEM ? mem_fwd_data : fwd_b_sel == FWD_WB ? wb_fwd_data : reg_file_out_data2;
    op_b = alu_src_out_id_ex ? sgn_ext_imm_out : op_b0;
    ctl = alu_decode(alu_op_out_id_ex, sgn_ext_imm_out[5:0], MUL_EN);
    is_mul = ctl == ALU_MUL;
    alu_res = ctl == ALU_ADD ? op_a + op_b :
              ctl == ALU_SUB ? op_a - op_b :
              ctl == ALU_AND ? op_a & op_b :
              ctl == ALU_OR  ? op_a | op_b :
              ctl == ALU_SLT ? DATA_W'($signed(op_a) < $signed(op_b)) :
              ctl == ALU_MUL ? mul_product : '0;
    // a presented MUL stalls until its product is ready in DONE
    ex_busy = mul_busy | (is_mul & ~mul_done);
  end
`ifdef EX_MUL_EN
  ex_seq_mul #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk(clk),
    .reset(reset),
    .start(is_mul & ~mul_busy & ~mul_done & ~flush),
    .abort(flush),
    .a(op_a),
    .b(op_b),
    .busy(mul_busy),
    .done(mul_done),
    .product(mul_product)
  );
`else
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_product = '0;
`endif
  always_ff @(negedge clk or posedge reset)
    if (reset || flush || ex_busy) begin
      reg_write_out_ex_mem <= 1'b0;
      mem_to_reg_out_ex_mem <= 1'b0;
      mem_write_out_ex_mem <= 1'b0;
      mem_read_out_ex_mem <= 1'b0;
      branch_out_ex_mem <= 1'b0;
      zero_out_ex_mem <= 1'b0;
      branch_target_out_ex_mem <= '0;
      alu_result_out_ex_mem <= '0;
      write_data_out_ex_mem <= '0;
      write_reg_out_ex_mem <= '0;
    end else begin
      reg_write_out_ex_mem <= reg_write_out_id_ex;
      mem_to_reg_out_ex_mem <= mem_to_reg_out_id_ex;
      mem_write_out_ex_mem <= mem_write_out_id_ex;
      mem_read_out_ex_mem <= mem_read_out_id_ex;
      branch_out_ex_mem <= branch_out_id_ex;
      zero_out_ex_mem <= alu_res == '0;
      branch_target_out_ex_mem <= nextpc_out + (sgn_ext_imm_out << 2);
      alu_result_out_ex_mem <= alu_res;
      write_data_out_ex_mem <= op_b0;
      write_reg_out_ex_mem <= reg_dst_id_ex ? rd_out_id_ex : inst_read_reg_addr2_out_id_ex;
    end
endmodule

// File: tb/tb_ex_stage_ex_mem.sv
// tb_ex_stage_ex_mem: directed-vector bench for ex_stage_ex_mem; multiplier vectors need EX_MUL_EN
module tb_ex_stage_ex_mem;
  logic clk = 1'b0, reset = 1'b1;
  logic reg_write, mem_to_reg, mem_write, mem_read, branch, alu_src, reg_dst, flush;
  logic [1:0] alu_op, fwd_a, fwd_b;
  logic [31:0] nextpc, data1, data2, imm, mem_fwd, wb_fwd;
  logic [4:0] rd, rt;
  logic ex_busy, reg_write_o, mem_to_reg_o, mem_write_o, mem_read_o, branch_o, zero_o;
  logic [31:0] target_o, alu_o, wdata_o;
  logic [4:0] wreg_o;
  int checks = 0, errors = 0;

  ex_stage_ex_mem dut (
    .clk(clk), .reset(reset),
    .reg_write_out_id_ex(reg_write), .mem_to_reg_out_id_ex(mem_to_reg),
    .mem_write_out_id_ex(mem_write), .mem_read_out_id_ex(mem_read),
    .branch_out_id_ex(branch), .alu_src_out_id_ex(alu_src), .reg_dst_id_ex(reg_dst),
    .alu_op_out_id_ex(alu_op), .nextpc_out(nextpc),
    .reg_file_out_data1(data1), .reg_file_out_data2(data2), .sgn_ext_imm_out(imm),
    .rd_out_id_ex(rd), .inst_read_reg_addr2_out_id_ex(rt),
    .fwd_a_sel(fwd_a), .fwd_b_sel(fwd_b), .mem_fwd_data(mem_fwd), .wb_fwd_data(wb_fwd),
    .flush(flush), .ex_busy(ex_busy),
    .reg_write_out_ex_mem(reg_write_o), .mem_to_reg_out_ex_mem(mem_to_reg_o),
    .mem_write_out_ex_mem(mem_write_o), .mem_read_out_ex_mem(mem_read_o),
    .branch_out_ex_mem(branch_o), .zero_out_ex_mem(zero_o),
    .branch_target_out_ex_mem(target_o), .alu_result_out_ex_mem(alu_o),
    .write_data_out_ex_mem(wdata_o), .write_reg_out_ex_mem(wreg_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic set_nop;
    {reg_write, mem_to_reg, mem_write, mem_read, branch, alu_src, reg_dst, flush} = '0;
    {alu_op, fwd_a, fwd_b} = '0;
    {nextpc, data1, data2, imm, mem_fwd, wb_fwd} = '0;
    {rd, rt} = '0;
  endtask

  task automatic alu_vec(input string tag, input logic [1:0] op, input logic [31:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_zero);
    set_nop;
    alu_op = op; imm = f; data1 = a; data2 = b; reg_write = 1'b1;
    tick;
    check({tag, "_res"}, alu_o, exp_res);
    check({tag, "_zero"}, 32'(zero_o), 32'(exp_zero));
  endtask

`ifdef EX_MUL_EN
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int n = 0, leaks = 0;
    set_nop;
    alu_op = 2'b10; imm = 32'h18; data1 = a; data2 = b; reg_write = 1'b1; reg_dst = 1'b1; rd = 5'd4;
    #1;
    while (ex_busy && n < 40) begin
      tick;
      n++;
      if (reg_write_o || alu_o != 0) leaks++;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd33);
    check({tag, "_bubbles"}, 32'(leaks), 32'd0);
    tick;
    check({tag, "_product"}, alu_o, exp);
    check({tag, "_reg_write"}, 32'(reg_write_o), 32'd1);
    check({tag, "_write_reg"}, 32'(wreg_o), 32'd4);
    set_nop;
    tick;
    check({tag, "_idle_busy"}, 32'(ex_busy), 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    set_nop;
    #12 reset = 1'b0;
    // forwarded A plus negative immediate
    fwd_a = 2'b01; mem_fwd = 32'h10; alu_src = 1'b1; imm = 32'hFFFFFFFC; data2 = 32'h33;
    reg_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; reg_dst = 1'b1; rd = 5'd3; rt = 5'd8;
    tick;
    check("fwd_imm_res", alu_o, 32'h0000000C);
    check("fwd_imm_wdata", wdata_o, 32'h33);
    check("fwd_imm_wreg", 32'(wreg_o), 32'd3);
    check("fwd_imm_ctl", 32'({reg_write_o, mem_read_o, mem_to_reg_o, mem_write_o, branch_o}), 32'b11100);
    check("fwd_imm_target", target_o, 32'hFFFFFFF0);
    // reset between edges clears outputs immediately
    set_nop;
    #2 reset = 1'b1;
    #1;
    check("rst_res", alu_o, 32'h0);
    check("rst_ctl", 32'({reg_write_o, mem_read_o, mem_to_reg_o, wreg_o}), 32'h0);
    check("rst_busy", 32'(ex_busy), 32'd0);
    reset = 1'b0;
    alu_vec("sub_funct", 2'b10, 32'h22, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
    alu_vec("sub_op", 2'b01, 32'h0, 32'd9, 32'd9, 32'h0, 1'b1);
    alu_vec("and", 2'b10, 32'h24, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0);
    alu_vec("or", 2'b10, 32'h25, 32'hF0F0, 32'h0F00, 32'hFFF0, 1'b0);
    alu_vec("slt_funct", 2'b10, 32'h2A, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    alu_vec("slt_op", 2'b11, 32'h0, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1);
    alu_vec("add_wrap", 2'b00, 32'h0, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0);
    alu_vec("bad_funct", 2'b10, 32'h3F, 32'd3, 32'd4, 32'd0, 1'b1);
    // B from writeback forward feeds both ALU and store data
    set_nop;
    fwd_a = 2'b11; fwd_b = 2'b10; data1 = 32'd1; data2 = 32'h99; wb_fwd = 32'h55; mem_write = 1'b1;
    tick;
    check("fwd_wb_res", alu_o, 32'h56);
    check("fwd_wb_wdata", wdata_o, 32'h55);
    check("fwd_wb_memw", 32'(mem_write_o), 32'd1);
    // branch target and rt destination
    set_nop;
    branch = 1'b1; nextpc = 32'h100; imm = 32'hFFFFFFFF; rt = 5'd7; rd = 5'd9;
    tick;
    check("br_target", target_o, 32'h000000FC);
    check("br_wreg", 32'(wreg_o), 32'd7);
    check("br_flag", 32'(branch_o), 32'd1);
    // flush squashes a valid instruction
    alu_vec("pre_flush", 2'b00, 32'h0, 32'd2, 32'd3, 32'd5, 1'b0);
    flush = 1'b1;
    tick;
    check("flush_res", alu_o, 32'h0);
    check("flush_rw", 32'(reg_write_o), 32'd0);
    flush = 1'b0;
`ifdef EX_MUL_EN
    run_mul("mul_neg", 32'hFFFFFFFD, 32'd6, 32'hFFFFFFEE);
    // abort a multiply with flush at iteration 10
    set_nop;
    alu_op = 2'b10; imm = 32'h18; data1 = 32'd7; data2 = 32'd7; reg_write = 1'b1;
    for (int i = 0; i < 11; i++) tick;
    check("abort_busy_before", 32'(ex_busy), 32'd1);
    flush = 1'b1;
    tick;
    check("abort_res", alu_o, 32'h0);
    check("abort_rw", 32'(reg_write_o), 32'd0);
    set_nop;
    #1;
    check("abort_busy_after", 32'(ex_busy), 32'd0);
    run_mul("mul_after_abort", 32'd3, 32'd4, 32'd12);
    // reset in the middle of a multiply
    set_nop;
    alu_op = 2'b10; imm = 32'h18; data1 = 32'd5; data2 = 32'd5; reg_write = 1'b1;
    for (int i = 0; i < 6; i++) tick;
    reset = 1'b1;
    set_nop;
    #1;
    check("rst_mul_busy", 32'(ex_busy), 32'd0);
    check("rst_mul_out", 32'({reg_write_o, wreg_o}) | alu_o, 32'h0);
    reset = 1'b0;
    run_mul("mul_after_rst", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
`else
    set_nop;
    alu_op = 2'b10; imm = 32'h18; data1 = 32'd3; data2 = 32'd4; reg_write = 1'b1;
    #1;
    check("nomul_busy", 32'(ex_busy), 32'd0);
    tick;
    check("nomul_res", alu_o, 32'h0);
    check("nomul_zero", 32'(zero_o), 32'd1);
    check("nomul_rw", 32'(reg_write_o), 32'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
